axi_lite_hub_n: RTL and testbench

Parametrised 1-master to N-slave AXI-lite crossbar hub. It is the next generation of the fixed three-slave hub used on the memory and MMIO buses.
- Generalised in slave count and address map.
- Adds decode-error responses (DECERR) for unmapped addresses; the fixed hub has none.
- Adds error telemetry for the debug LEDs and cosim.
- Read and write channels are tracked independently, one outstanding transaction per direction.

---
 rtl/axi_hub_pkg.sv | 16 +
 rtl/axi_lite_addr_decoder.sv | 33 +++
 rtl/axi_lite_hub_n.sv | 258 +++++++++++++++++++++++++
 tb/tb_axi_lite_hub_n.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_hub_pkg.sv
// Shared types and response codes for the parametrised AXI-lite hub.
package axi_hub_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {W_IDLE, W_FWD, W_RESP, W_ERRD, W_ERRB} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FWD, R_DATA, R_ERR} rstate_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } sel_t;

endpackage

// File: rtl/axi_lite_addr_decoder.sv
// Combinational address decoder: maps an address onto the lowest-index slave region it falls in.
module axi_lite_addr_decoder
    import axi_hub_pkg::*;
#(
    parameter int unsigned                   NUM_SLAVES = 4,
    parameter int unsigned                   ADDR_W     = 64,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_BASE   = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_LEN    = '0
) (
    input  logic [ADDR_W-1:0] addr_i,
    output sel_t              sel_o
);

    logic [ADDR_W:0] base;
    logic [ADDR_W:0] limit;

    // Walk downwards so the lowest matching index is the one left standing.
    always_comb begin
        sel_o = '0;
        base  = '0;
        limit = '0;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            base  = {1'b0, SLV_BASE[i*ADDR_W +: ADDR_W]};
            limit = base + {1'b0, SLV_LEN[i*ADDR_W +: ADDR_W]};
            if ((SLV_LEN[i*ADDR_W +: ADDR_W] != '0) && ({1'b0, addr_i} >= base) &&
                ({1'b0, addr_i} < limit)) begin
                sel_o.hit = 1'b1;
                sel_o.idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/axi_lite_hub_n.sv
// 1-master to N-slave AXI-lite hub with independent read/write tracking and decode-error telemetry.
module axi_lite_hub_n
    import axi_hub_pkg::*;
#(
    parameter int unsigned                   NUM_SLAVES = 4,
    parameter int unsigned                   ADDR_W     = 64,
    parameter int unsigned                   DATA_W     = 64,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_BASE   = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_LEN    = '0,
    parameter int unsigned                   ERR_CNT_W  = 16
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  m_awvalid_i,
    output logic                                  m_awready_o,
    input  logic [ADDR_W-1:0]                     m_awaddr_i,
    input  logic [2:0]                            m_awprot_i,
    input  logic                                  m_wvalid_i,
    output logic                                  m_wready_o,
    input  logic [DATA_W-1:0]                     m_wdata_i,
    input  logic [DATA_W/8-1:0]                   m_wstrb_i,
    output logic                                  m_bvalid_o,
    input  logic                                  m_bready_i,
    output logic [1:0]                            m_bresp_o,
    input  logic                                  m_arvalid_i,
    output logic                                  m_arready_o,
    input  logic [ADDR_W-1:0]                     m_araddr_i,
    input  logic [2:0]                            m_arprot_i,
    output logic                                  m_rvalid_o,
    input  logic                                  m_rready_i,
    output logic [DATA_W-1:0]                     m_rdata_o,
    output logic [1:0]                            m_rresp_o,
    output logic [NUM_SLAVES-1:0]                 s_awvalid_o,
    input  logic [NUM_SLAVES-1:0]                 s_awready_i,
    output logic [NUM_SLAVES-1:0][ADDR_W-1:0]     s_awaddr_o,
    output logic [NUM_SLAVES-1:0][2:0]            s_awprot_o,
    output logic [NUM_SLAVES-1:0]                 s_wvalid_o,
    input  logic [NUM_SLAVES-1:0]                 s_wready_i,
    output logic [NUM_SLAVES-1:0][DATA_W-1:0]     s_wdata_o,
    output logic [NUM_SLAVES-1:0][DATA_W/8-1:0]   s_wstrb_o,
    input  logic [NUM_SLAVES-1:0]                 s_bvalid_i,
    output logic [NUM_SLAVES-1:0]                 s_bready_o,
    input  logic [NUM_SLAVES-1:0][1:0]            s_bresp_i,
    output logic [NUM_SLAVES-1:0]                 s_arvalid_o,
    input  logic [NUM_SLAVES-1:0]                 s_arready_i,
    output logic [NUM_SLAVES-1:0][ADDR_W-1:0]     s_araddr_o,
    output logic [NUM_SLAVES-1:0][2:0]            s_arprot_o,
    input  logic [NUM_SLAVES-1:0]                 s_rvalid_i,
    output logic [NUM_SLAVES-1:0]                 s_rready_o,
    input  logic [NUM_SLAVES-1:0][DATA_W-1:0]     s_rdata_i,
    input  logic [NUM_SLAVES-1:0][1:0]            s_rresp_i,
    output logic [ERR_CNT_W-1:0]                  dec_err_cnt,
    output logic [ADDR_W-1:0]                     last_err_addr,
    output logic                                  err_pulse
);

    sel_t aw_sel, ar_sel;

    axi_lite_addr_decoder #(
        .NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_LEN(SLV_LEN)
    ) u_aw_dec (
        .addr_i(m_awaddr_i),
        .sel_o (aw_sel)
    );

    axi_lite_addr_decoder #(
        .NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_LEN(SLV_LEN)
    ) u_ar_dec (
        .addr_i(m_araddr_i),
        .sel_o (ar_sel)
    );

    wstate_t               w_state_q;
    rstate_t               r_state_q;
    sel_t                  w_sel_q, r_sel_q;
    logic [ADDR_W-1:0]     aw_addr_q, ar_addr_q;
    logic [2:0]            aw_prot_q, ar_prot_q;
    logic                  aw_done_q, w_done_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ERR_CNT_W:0]    err_sum;
    logic [ADDR_W-1:0]     err_addr_q;

    logic [NUM_SLAVES-1:0] w_oh, r_oh;
    logic                  s_aw_rdy, s_w_rdy, s_b_vld, s_ar_rdy, s_r_vld;
    logic [1:0]            s_b_resp, s_r_resp;
    logic [DATA_W-1:0]     s_r_data;
    logic                  aw_hs, w_hs, b_hs, s_aw_hs, ar_hs, r_hs, s_ar_hs;
    logic                  w_miss, r_miss;

    always_comb begin
        w_oh     = '0;
        r_oh     = '0;
        s_b_resp = RESP_OKAY;
        s_r_resp = RESP_OKAY;
        s_r_data = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            w_oh[i] = (w_sel_q.idx == 4'(i));
            r_oh[i] = (r_sel_q.idx == 4'(i));
            if (w_oh[i]) s_b_resp = s_bresp_i[i];
            if (r_oh[i]) begin
                s_r_resp = s_rresp_i[i];
                s_r_data = s_rdata_i[i];
            end
        end
        s_aw_rdy = |(w_oh & s_awready_i);
        s_w_rdy  = |(w_oh & s_wready_i);
        s_b_vld  = |(w_oh & s_bvalid_i);
        s_ar_rdy = |(r_oh & s_arready_i);
        s_r_vld  = |(r_oh & s_rvalid_i);
    end

    // Outputs are gated by rstn so nothing handshakes while reset is held.
    always_comb begin
        m_awready_o = 1'b0;
        m_wready_o  = 1'b0;
        m_bvalid_o  = 1'b0;
        m_bresp_o   = RESP_OKAY;
        s_awvalid_o = '0;
        s_wvalid_o  = '0;
        s_bready_o  = '0;
        if (rstn) begin
            unique case (w_state_q)
                W_IDLE: m_awready_o = 1'b1;
                W_FWD: begin
                    s_awvalid_o = aw_done_q ? '0 : w_oh;
                    s_wvalid_o  = (m_wvalid_i && !w_done_q) ? w_oh : '0;
                    m_wready_o  = s_w_rdy && !w_done_q;
                end
                W_RESP: begin
                    m_bvalid_o = s_b_vld;
                    m_bresp_o  = s_b_resp;
                    s_bready_o = m_bready_i ? w_oh : '0;
                end
                W_ERRD: m_wready_o = 1'b1;
                W_ERRB: begin
                    m_bvalid_o = 1'b1;
                    m_bresp_o  = RESP_DECERR;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m_arready_o = 1'b0;
        m_rvalid_o  = 1'b0;
        m_rdata_o   = '0;
        m_rresp_o   = RESP_OKAY;
        s_arvalid_o = '0;
        s_rready_o  = '0;
        if (rstn) begin
            unique case (r_state_q)
                R_IDLE: m_arready_o = 1'b1;
                R_FWD:  s_arvalid_o = r_oh;
                R_DATA: begin
                    m_rvalid_o = s_r_vld;
                    m_rdata_o  = s_r_data;
                    m_rresp_o  = s_r_resp;
                    s_rready_o = m_rready_i ? r_oh : '0;
                end
                R_ERR: begin
                    m_rvalid_o = 1'b1;
                    m_rresp_o  = RESP_DECERR;
                end
                default: ;
            endcase
        end
    end

    assign aw_hs   = m_awvalid_i && m_awready_o;
    assign w_hs    = m_wvalid_i && m_wready_o;
    assign b_hs    = m_bvalid_o && m_bready_i;
    assign s_aw_hs = s_aw_rdy && (|s_awvalid_o);
    assign ar_hs   = m_arvalid_i && m_arready_o;
    assign r_hs    = m_rvalid_o && m_rready_i;
    assign s_ar_hs = s_ar_rdy && (|s_arvalid_o);

    assign s_awaddr_o = {NUM_SLAVES{aw_addr_q}};
    assign s_awprot_o = {NUM_SLAVES{aw_prot_q}};
    assign s_wdata_o  = {NUM_SLAVES{m_wdata_i}};
    assign s_wstrb_o  = {NUM_SLAVES{m_wstrb_i}};
    assign s_araddr_o = {NUM_SLAVES{ar_addr_q}};
    assign s_arprot_o = {NUM_SLAVES{ar_prot_q}};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            w_sel_q   <= '0;
            aw_addr_q <= '0;
            aw_prot_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            unique case (w_state_q)
                W_IDLE: if (aw_hs) begin
                    w_sel_q   <= aw_sel;
                    aw_addr_q <= m_awaddr_i;
                    aw_prot_q <= m_awprot_i;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    w_state_q <= aw_sel.hit ? W_FWD : W_ERRD;
                end
                W_FWD: begin
                    if (s_aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)    w_done_q  <= 1'b1;
                    if ((aw_done_q || s_aw_hs) && (w_done_q || w_hs)) w_state_q <= W_RESP;
                end
                W_RESP: if (b_hs) w_state_q <= W_IDLE;
                W_ERRD: if (w_hs) w_state_q <= W_ERRB;
                W_ERRB: if (b_hs) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state_q <= R_IDLE;
            r_sel_q   <= '0;
            ar_addr_q <= '0;
            ar_prot_q <= '0;
        end else begin
            unique case (r_state_q)
                R_IDLE: if (ar_hs) begin
                    r_sel_q   <= ar_sel;
                    ar_addr_q <= m_araddr_i;
                    ar_prot_q <= m_arprot_i;
                    r_state_q <= ar_sel.hit ? R_FWD : R_ERR;
                end
                R_FWD:  if (s_ar_hs) r_state_q <= R_DATA;
                R_DATA: if (r_hs) r_state_q <= R_IDLE;
                R_ERR:  if (r_hs) r_state_q <= R_IDLE;
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign w_miss  = aw_hs && !aw_sel.hit;
    assign r_miss  = ar_hs && !ar_sel.hit;
    assign err_sum = {1'b0, err_cnt_q} + (ERR_CNT_W+1)'(w_miss) + (ERR_CNT_W+1)'(r_miss);
    assign err_cnt_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            if (w_miss)      err_addr_q <= m_awaddr_i;
            else if (r_miss) err_addr_q <= m_araddr_i;
        end
    end

    assign dec_err_cnt   = err_cnt_q;
    assign last_err_addr = err_addr_q;
    assign err_pulse     = w_miss || r_miss;

endmodule

// File: tb/tb_axi_lite_hub_n.sv
// Directed bench for axi_lite_hub_n; a second instance with a 2-bit counter exercises saturation.
module tb_axi_lite_hub_n;
    import axi_hub_pkg::*;

    localparam int unsigned NS = 4;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam logic [NS*AW-1:0] BASE = {64'h2000_0000, 64'h8000_0000, 64'h1000, 64'h0};
    localparam logic [NS*AW-1:0] LEN  = {64'h100, 64'h10_0000, 64'h1000, 64'h1000};

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic                     m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic                     m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW-1:0]            m_awaddr, m_araddr;
    logic [2:0]               m_awprot, m_arprot;
    logic [DW-1:0]            m_wdata, m_rdata;
    logic [DW/8-1:0]          m_wstrb;
    logic [1:0]               m_bresp, m_rresp;
    logic [NS-1:0]            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [NS-1:0]            s_arvalid, s_arready, s_rvalid, s_rready;
    logic [NS-1:0][AW-1:0]    s_awaddr, s_araddr;
    logic [NS-1:0][2:0]       s_awprot, s_arprot;
    logic [NS-1:0][DW-1:0]    s_wdata, s_rdata;
    logic [NS-1:0][DW/8-1:0]  s_wstrb;
    logic [NS-1:0][1:0]       s_bresp, s_rresp;
    logic [15:0]              dec_err_cnt;
    logic [AW-1:0]            last_err_addr;
    logic                     err_pulse;

    logic                     x_awready, x_wready, x_bvalid, x_arready, x_rvalid, x_err_pulse;
    logic [1:0]               x_bresp, x_rresp, x_cnt;
    logic [DW-1:0]            x_rdata;
    logic [NS-1:0]            x_awvalid, x_wvalid, x_bready, x_arvalid, x_rready;
    logic [NS-1:0][AW-1:0]    x_awaddr, x_araddr;
    logic [NS-1:0][2:0]       x_awprot, x_arprot;
    logic [NS-1:0][DW-1:0]    x_wdata;
    logic [NS-1:0][DW/8-1:0]  x_wstrb;
    logic [AW-1:0]            x_err_addr;

    axi_lite_hub_n #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SLV_BASE(BASE), .SLV_LEN(LEN),
                     .ERR_CNT_W(16)) dut (
        .clk(clk), .rstn(rstn),
        .m_awvalid_i(m_awvalid), .m_awready_o(m_awready), .m_awaddr_i(m_awaddr),
        .m_awprot_i(m_awprot), .m_wvalid_i(m_wvalid), .m_wready_o(m_wready),
        .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb), .m_bvalid_o(m_bvalid), .m_bready_i(m_bready),
        .m_bresp_o(m_bresp), .m_arvalid_i(m_arvalid), .m_arready_o(m_arready),
        .m_araddr_i(m_araddr), .m_arprot_i(m_arprot), .m_rvalid_o(m_rvalid),
        .m_rready_i(m_rready), .m_rdata_o(m_rdata), .m_rresp_o(m_rresp),
        .s_awvalid_o(s_awvalid), .s_awready_i(s_awready), .s_awaddr_o(s_awaddr),
        .s_awprot_o(s_awprot), .s_wvalid_o(s_wvalid), .s_wready_i(s_wready),
        .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb), .s_bvalid_i(s_bvalid), .s_bready_o(s_bready),
        .s_bresp_i(s_bresp), .s_arvalid_o(s_arvalid), .s_arready_i(s_arready),
        .s_araddr_o(s_araddr), .s_arprot_o(s_arprot), .s_rvalid_i(s_rvalid),
        .s_rready_o(s_rready), .s_rdata_i(s_rdata), .s_rresp_i(s_rresp),
        .dec_err_cnt(dec_err_cnt), .last_err_addr(last_err_addr), .err_pulse(err_pulse)
    );

    axi_lite_hub_n #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SLV_BASE(BASE), .SLV_LEN(LEN),
                     .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn),
        .m_awvalid_i(m_awvalid), .m_awready_o(x_awready), .m_awaddr_i(m_awaddr),
        .m_awprot_i(m_awprot), .m_wvalid_i(m_wvalid), .m_wready_o(x_wready),
        .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb), .m_bvalid_o(x_bvalid), .m_bready_i(m_bready),
        .m_bresp_o(x_bresp), .m_arvalid_i(m_arvalid), .m_arready_o(x_arready),
        .m_araddr_i(m_araddr), .m_arprot_i(m_arprot), .m_rvalid_o(x_rvalid),
        .m_rready_i(m_rready), .m_rdata_o(x_rdata), .m_rresp_o(x_rresp),
        .s_awvalid_o(x_awvalid), .s_awready_i(s_awready), .s_awaddr_o(x_awaddr),
        .s_awprot_o(x_awprot), .s_wvalid_o(x_wvalid), .s_wready_i(s_wready),
        .s_wdata_o(x_wdata), .s_wstrb_o(x_wstrb), .s_bvalid_i(s_bvalid), .s_bready_o(x_bready),
        .s_bresp_i(s_bresp), .s_arvalid_o(x_arvalid), .s_arready_i(s_arready),
        .s_araddr_o(x_araddr), .s_arprot_o(x_arprot), .s_rvalid_i(s_rvalid),
        .s_rready_o(x_rready), .s_rdata_i(s_rdata), .s_rresp_i(s_rresp),
        .dec_err_cnt(x_cnt), .last_err_addr(x_err_addr), .err_pulse(x_err_pulse)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_hit(input string tag, input logic [63:0] addr, input logic [3:0] oh);
        m_arvalid = 1'b1;
        m_araddr  = addr;
        tick();
        m_arvalid = 1'b0;
        #1;
        chk({tag, " arvalid"}, 64'(s_arvalid), 64'(oh));
        s_arready = oh;
        tick();
        s_arready = '0;
        s_rvalid  = oh;
        m_rready  = 1'b1;
        #1;
        chk({tag, " rvalid"}, 64'(m_rvalid), 64'h1);
        tick();
        s_rvalid = '0;
        m_rready = 1'b0;
    endtask

    task automatic rd_miss(input string tag, input logic [63:0] addr);
        m_arvalid = 1'b1;
        m_araddr  = addr;
        tick();
        m_arvalid = 1'b0;
        #1;
        chk({tag, " rresp"}, {62'h0, m_rresp} | {63'h0, !m_rvalid}, 64'h3);
        m_rready = 1'b1;
        tick();
        m_rready = 1'b0;
    endtask

    initial begin
        m_awvalid = 0; m_awaddr = '0; m_awprot = '0; m_wvalid = 0; m_wdata = '0; m_wstrb = '0;
        m_bready = 0; m_arvalid = 0; m_araddr = '0; m_arprot = '0; m_rready = 0;
        s_awready = '0; s_wready = '0; s_bvalid = '0; s_bresp = '0; s_arready = '0;
        s_rvalid = '0; s_rdata = '0; s_rresp = '0;

        // Reset held
        tick(); tick();
        chk("rst awready", 64'(m_awready), 64'h0);
        chk("rst arready", 64'(m_arready), 64'h0);
        chk("rst cnt", 64'(dec_err_cnt), 64'h0);
        chk("rst errpulse", 64'(err_pulse), 64'h0);
        rstn = 1'b1;
        #1;
        chk("idle awready", 64'(m_awready), 64'h1);
        chk("idle arready", 64'(m_arready), 64'h1);

        // Write 0xDEADBEEF to 0x1008, W leading AW by 3 cycles
        m_wvalid = 1; m_wdata = 64'hDEAD_BEEF; m_wstrb = 8'hFF; s_wready = 4'b0001;
        tick(); tick(); tick();
        chk("wr early wready", 64'(m_wready), 64'h0);
        chk("wr early swvalid", 64'(s_wvalid), 64'h0);
        m_awvalid = 1; m_awaddr = 64'h1008; m_awprot = 3'b010;
        tick();
        m_awvalid = 0;
        #1;
        chk("wr awvalid", 64'(s_awvalid), 64'h2);
        chk("wr awaddr", s_awaddr[1], 64'h1008);
        chk("wr awprot", 64'(s_awprot[1]), 64'h2);
        chk("wr swvalid", 64'(s_wvalid), 64'h2);
        chk("wr wdata", s_wdata[1], 64'hDEAD_BEEF);
        chk("wr wready unsel", 64'(m_wready), 64'h0);
        s_wready = 4'b0010;
        #1;
        chk("wr wready sel", 64'(m_wready), 64'h1);
        tick();
        s_wready = '0; m_wvalid = 0; s_awready = 4'b0010;
        #1;
        chk("wr swvalid done", 64'(s_wvalid), 64'h0);
        chk("wr awvalid held", 64'(s_awvalid), 64'h2);
        tick();
        s_awready = '0;
        s_bvalid = 4'b0010; s_bresp = 8'b00_00_00_10; m_bready = 1;
        #1;
        chk("wr awvalid drop", 64'(s_awvalid), 64'h0);
        chk("wr bvalid", 64'(m_bvalid), 64'h1);
        chk("wr bresp", 64'(m_bresp), 64'h0);
        chk("wr bready", 64'(s_bready), 64'h2);
        tick();
        s_bvalid = '0; s_bresp = '0; m_bready = 0;
        #1;
        chk("wr back idle", 64'(m_awready), 64'h1);
        chk("wr cnt", 64'(dec_err_cnt), 64'h0);

        // Read 0x8000_0010 from slave 2, data 5 cycles later
        m_arvalid = 1; m_araddr = 64'h8000_0010;
        tick();
        m_arvalid = 0;
        #1;
        chk("rd arvalid", 64'(s_arvalid), 64'h4);
        chk("rd araddr", s_araddr[2], 64'h8000_0010);
        s_arready = 4'b0100;
        tick();
        s_arready = '0;
        #1;
        chk("rd arvalid drop", 64'(s_arvalid), 64'h0);
        tick(); tick(); tick(); tick();
        chk("rd wait rvalid", 64'(m_rvalid), 64'h0);
        s_rvalid = 4'b0100; s_rdata[2] = 64'h1234; s_rdata[0] = 64'hBAD;
        s_rresp = 8'b11_00_00_10; m_rready = 1;
        #1;
        chk("rd rvalid", 64'(m_rvalid), 64'h1);
        chk("rd rdata", m_rdata, 64'h1234);
        chk("rd rresp", 64'(m_rresp), 64'h0);
        chk("rd rready", 64'(s_rready), 64'h4);
        tick();
        s_rvalid = '0; s_rdata = '0; s_rresp = '0; m_rready = 0;

        // Unmapped read
        m_arvalid = 1; m_araddr = 64'h3000_0000;
        #1;
        chk("rmiss pulse", 64'(err_pulse), 64'h1);
        tick();
        m_arvalid = 0;
        #1;
        chk("rmiss pulse gone", 64'(err_pulse), 64'h0);
        chk("rmiss rvalid", 64'(m_rvalid), 64'h1);
        chk("rmiss rresp", 64'(m_rresp), 64'h3);
        chk("rmiss rdata", m_rdata, 64'h0);
        chk("rmiss cnt", 64'(dec_err_cnt), 64'h1);
        chk("rmiss addr", last_err_addr, 64'h3000_0000);
        chk("rmiss no arvalid", 64'(s_arvalid), 64'h0);
        chk("rmiss sat cnt", 64'(x_cnt), 64'h1);
        m_rready = 1;
        tick();
        m_rready = 0;
        #1;
        chk("rmiss done", 64'(m_rvalid), 64'h0);

        // Simultaneous write and read miss
        m_awvalid = 1; m_awaddr = 64'h5000; m_arvalid = 1; m_araddr = 64'h9000_0000;
        #1;
        chk("dual pulse", 64'(err_pulse), 64'h1);
        tick();
        m_awvalid = 0; m_arvalid = 0;
        #1;
        chk("dual cnt", 64'(dec_err_cnt), 64'h3);
        chk("dual addr", last_err_addr, 64'h5000);
        chk("dual rresp", 64'(m_rresp), 64'h3);
        chk("dual wready", 64'(m_wready), 64'h1);
        chk("dual bvalid early", 64'(m_bvalid), 64'h0);
        chk("dual sat cnt", 64'(x_cnt), 64'h3);
        m_wvalid = 1; m_rready = 1;
        tick();
        m_wvalid = 0; m_rready = 0;
        #1;
        chk("dual swvalid", 64'(s_wvalid), 64'h0);
        chk("dual bvalid", 64'(m_bvalid), 64'h1);
        chk("dual bresp", 64'(m_bresp), 64'h3);
        m_bready = 1;
        tick();
        m_bready = 0;
        #1;
        chk("dual idle", 64'(m_awready), 64'h1);

        // Region boundaries
        rd_hit("b 0fff", 64'h0FFF, 4'b0001);
        rd_hit("b 1000", 64'h1000, 4'b0010);
        rd_hit("b 200000ff", 64'h2000_00FF, 4'b1000);
        rd_miss("b 20000100", 64'h2000_0100);
        chk("b cnt", 64'(dec_err_cnt), 64'h4);
        chk("b addr", last_err_addr, 64'h2000_0100);

        // Three more misses: wide counter counts, 2-bit counter holds at all-ones
        rd_miss("sat m1", 64'hFFFF_0000);
        rd_miss("sat m2", 64'hFFFF_0004);
        rd_miss("sat m3", 64'hFFFF_0008);
        chk("sat cnt wide", 64'(dec_err_cnt), 64'h7);
        chk("sat cnt held", 64'(x_cnt), 64'h3);

        // Reset in W_FWD
        m_awvalid = 1; m_awaddr = 64'h1000;
        tick();
        m_awvalid = 0;
        #1;
        chk("rstfwd awvalid", 64'(s_awvalid), 64'h2);
        rstn = 0;
        tick();
        chk("rstfwd drop", 64'(s_awvalid), 64'h0);
        chk("rstfwd awready", 64'(m_awready), 64'h0);
        chk("rstfwd cnt", 64'(dec_err_cnt), 64'h0);
        chk("rstfwd addr", last_err_addr, 64'h0);
        chk("rstfwd sat cnt", 64'(x_cnt), 64'h0);
        rstn = 1;
        #1;
        chk("rstfwd idle", 64'(m_awready), 64'h1);
        m_awvalid = 1; m_awaddr = 64'h0; m_wvalid = 1; m_wdata = 64'h55;
        tick();
        m_awvalid = 0;
        s_awready = 4'b0001; s_wready = 4'b0001;
        #1;
        chk("post awvalid", 64'(s_awvalid), 64'h1);
        tick();
        s_awready = '0; s_wready = '0; m_wvalid = 0;
        s_bvalid = 4'b0001; m_bready = 1;
        #1;
        chk("post bvalid", 64'(m_bvalid), 64'h1);
        chk("post bresp", 64'(m_bresp), 64'h0);
        tick();
        s_bvalid = '0; m_bready = 0;
        #1;
        chk("post idle", 64'(m_awready), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
